// File: rtl/sargantana_icache_ifill_unit_pkg.sv
// Shared types and sizes for the I$ refill engine: FSM states, request/response structs, beat geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sargantana_icache_ifill_unit_pkg;

    localparam int PHY_ADDR_SIZE     = 40;
    localparam int ICACHELINE_SIZE   = 512;
    localparam int ICACHE_INDEX_SIZE = 12;

    localparam int IFILL_BEAT_W = 64;
    localparam int IFILL_BEATS  = ICACHELINE_SIZE / IFILL_BEAT_W;
    localparam int IFILL_CNT_W  = $clog2(IFILL_BEATS);
    // Byte-offset bits inside one line; these are forced to zero on the memory address.
    localparam int IFILL_OFF_W  = $clog2(ICACHELINE_SIZE / 8);

    typedef enum logic [1:0] {
        IFILL_IDLE,
        IFILL_REQ,
        IFILL_FILL,
        IFILL_RESP
    } ifill_state_t;

    typedef struct packed {
        logic                     valid;
        logic [PHY_ADDR_SIZE-1:0] paddr;
    } ifill_req_o_t;

    typedef struct packed {
        logic                         valid;
        logic [ICACHE_INDEX_SIZE-1:0] paddr;
    } ifill_inv_t;

    typedef struct packed {
        logic                       valid;
        logic                       ack;
        logic [ICACHELINE_SIZE-1:0] data;
        ifill_inv_t                 inv;
    } ifill_resp_i_t;

endpackage

// File: rtl/sargantana_icache_ifill_unit_if.sv
// Bundles the I$-side and memory-side signals of the refill engine.
// Latency: n/a (wiring only).
// Backpressure: mem request uses valid/ready; mem beats and I$ responses carry no backpressure.
// Modports: slave = refill engine view, master = environment (I$ ctrl + memory) view.
interface sargantana_icache_ifill_unit_if;
    import sargantana_icache_ifill_unit_pkg::*;

    ifill_req_o_t              ifill_req_i;
    ifill_resp_i_t             ifill_resp_o;
    logic                      flush_i;
    logic                      mem_req_valid_o;
    logic                      mem_req_ready_i;
    logic [PHY_ADDR_SIZE-1:0]  mem_req_addr_o;
    logic                      mem_resp_valid_i;
    logic [IFILL_BEAT_W-1:0]   mem_resp_data_i;
    logic                      inv_valid_i;
    logic [PHY_ADDR_SIZE-1:0]  inv_paddr_i;
    logic                      busy_o;

    modport slave (
        input  ifill_req_i, flush_i, mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
               inv_valid_i, inv_paddr_i,
        output ifill_resp_o, mem_req_valid_o, mem_req_addr_o, busy_o
    );

    modport master (
        output ifill_req_i, flush_i, mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
               inv_valid_i, inv_paddr_i,
        input  ifill_resp_o, mem_req_valid_o, mem_req_addr_o, busy_o
    );

endinterface

// File: rtl/sargantana_icache_ifill_unit_linebuf.sv
// Line assembly register: decodes the beat index into a per-beat write enable and stores the beat.
// Latency: a beat is visible on line one cycle after wr_en.
// Backpressure: none; every enabled beat is written.
// Ports: clk_i/rst_i (async active-high clear), wr_en, beat_idx, beat_data in; line out.
module sargantana_icache_ifill_linebuf #(
    parameter int LINE_W = 512,
    parameter int BEAT_W = 64,
    parameter int CNT_W  = $clog2(LINE_W / BEAT_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  beat_idx,
    input  logic [BEAT_W-1:0] beat_data,
    output logic [LINE_W-1:0] line
);

    localparam int BEATS = LINE_W / BEAT_W;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line <= '0;
        end else if (wr_en) begin
            // Beat 0 lands in the least significant slice.
            for (int b = 0; b < BEATS; b++) begin
                if (beat_idx == CNT_W'(b)) begin
                    line[b*BEAT_W +: BEAT_W] <= beat_data;
                end
            end
        end
    end

endmodule

// File: rtl/sargantana_icache_ifill_unit.sv
// I$ refill engine: one outstanding line fill, one line-aligned memory read, beats assembled into a line.
// Latency: req accepted at cycle 0 -> mem req at cycle 1 -> resp.valid one cycle after the last beat.
// Backpressure: mem request held until ready; beats have no backpressure; flush/inv hits drop the line.
// Ports: clk_i, rst_i (async active-high); ifill_bus (slave modport) carries the I$ request/response,
//        flush, invalidation input, memory request/beat channels and busy.
module sargantana_icache_ifill_unit
    import sargantana_icache_ifill_unit_pkg::*;
#(
    parameter int LINE_W  = ICACHELINE_SIZE,
    parameter int BEAT_W  = IFILL_BEAT_W,
    parameter int PADDR_W = PHY_ADDR_SIZE
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    sargantana_icache_ifill_unit_if.slave  ifill_bus
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_W / 8);

    ifill_state_t      state;
    logic [CNT_W-1:0]  beat_cnt;
    logic              drop;
    logic              ack_q;
    logic              mem_req_valid_q;
    logic [PADDR_W-1:0] paddr_q;
    ifill_inv_t        inv_q;
    logic [LINE_W-1:0] line;
    logic              inv_hit;
    logic              beat_wr;
    logic              resp_valid;
    logic              unused_offset;

    // Byte offset of the requested address never reaches the memory side.
    assign unused_offset = ^ifill_bus.ifill_req_i.paddr[OFF_W-1:0];

    // Invalidation hits compare line addresses only; the latched paddr is already aligned.
    assign inv_hit = ifill_bus.inv_valid_i &&
                     (ifill_bus.inv_paddr_i[PADDR_W-1:OFF_W] == paddr_q[PADDR_W-1:OFF_W]);

    // Beats outside FILL are protocol errors and must not corrupt the line.
    assign beat_wr = (state == IFILL_FILL) && ifill_bus.mem_resp_valid_i;

    // Flush and a same-cycle invalidation hit both gate the response combinationally in RESP,
    // so a stale line is never handed up even if the kill arrives on the last cycle.
    assign resp_valid = (state == IFILL_RESP) && !drop && !ifill_bus.flush_i && !inv_hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IFILL_IDLE;
            beat_cnt        <= '0;
            drop            <= 1'b0;
            ack_q           <= 1'b0;
            mem_req_valid_q <= 1'b0;
            paddr_q         <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                IFILL_IDLE: begin
                    if (ifill_bus.ifill_req_i.valid) begin
                        paddr_q         <= {ifill_bus.ifill_req_i.paddr[PADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        drop            <= 1'b0;
                        ack_q           <= 1'b1;
                        mem_req_valid_q <= 1'b1;
                        state           <= IFILL_REQ;
                    end
                end
                IFILL_REQ: begin
                    // A killed fill still completes its handshake so memory sees a clean transaction.
                    if (ifill_bus.flush_i || inv_hit) begin
                        drop <= 1'b1;
                    end
                    if (ifill_bus.mem_req_ready_i) begin
                        mem_req_valid_q <= 1'b0;
                        state           <= IFILL_FILL;
                    end
                end
                IFILL_FILL: begin
                    if (ifill_bus.flush_i || inv_hit) begin
                        drop <= 1'b1;
                    end
                    if (ifill_bus.mem_resp_valid_i) begin
                        if (beat_cnt == CNT_W'(BEATS - 1)) begin
                            beat_cnt <= '0;
                            state    <= IFILL_RESP;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                IFILL_RESP: begin
                    state <= IFILL_IDLE;
                end
                default: begin
                    state <= IFILL_IDLE;
                end
            endcase
        end
    end

    // Invalidation forwarding is a plain one-cycle pipe, independent of the fill state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inv_q <= '0;
        end else begin
            inv_q.valid <= ifill_bus.inv_valid_i;
            inv_q.paddr <= ifill_bus.inv_paddr_i[ICACHE_INDEX_SIZE-1:0];
        end
    end

    sargantana_icache_ifill_linebuf #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .CNT_W  (CNT_W)
    ) u_linebuf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en     (beat_wr),
        .beat_idx  (beat_cnt),
        .beat_data (ifill_bus.mem_resp_data_i),
        .line      (line)
    );

    assign ifill_bus.ifill_resp_o.valid = resp_valid;
    assign ifill_bus.ifill_resp_o.ack   = ack_q;
    assign ifill_bus.ifill_resp_o.data  = line;
    assign ifill_bus.ifill_resp_o.inv   = inv_q;
    assign ifill_bus.mem_req_valid_o    = mem_req_valid_q;
    assign ifill_bus.mem_req_addr_o     = paddr_q;
    assign ifill_bus.busy_o             = (state != IFILL_IDLE);

    mem_resp_only_in_fill: assert property (
        @(posedge clk_i) disable iff (rst_i) ifill_bus.mem_resp_valid_i |-> (state == IFILL_FILL)
    );

endmodule

// File: tb/tb_sargantana_icache_ifill_unit.sv
// Self-checking bench for the I$ refill engine: expected lines are queued when a fill is started
// and compared when the DUT raises resp.valid; handshake, latency, flush, invalidation and reset
// behaviour are checked inline.
module tb_sargantana_icache_ifill_unit;
    import sargantana_icache_ifill_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sargantana_icache_ifill_unit_if bus ();

    sargantana_icache_ifill_unit dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .ifill_bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_ack    = 0;
    int n_resp   = 0;
    logic [ICACHELINE_SIZE-1:0] exp_q[$];

    task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ICACHELINE_SIZE-1:0] make_line(input logic [63:0] seed);
        logic [ICACHELINE_SIZE-1:0] l;
        for (int i = 0; i < IFILL_BEATS; i++) l[i*IFILL_BEAT_W +: IFILL_BEAT_W] = seed + 64'(i);
        return l;
    endfunction

    // Scoreboard side: every response pulse must match the oldest queued line.
    always @(negedge clk) begin
        if (bus.ifill_resp_o.ack) n_ack++;
        if (bus.ifill_resp_o.valid) begin
            n_resp++;
            if (exp_q.size() == 0) begin
                check("resp_unexpected", bus.ifill_resp_o.valid, 1'b0);
            end else begin
                check("resp_data", bus.ifill_resp_o.data, exp_q.pop_front());
            end
        end
    end

    task automatic run_fill(input logic [39:0] pa, input int ready_lat, input int gap,
                            input int flush_beat, input int inv_beat, input logic [39:0] inv_pa,
                            input bit exp_resp, input logic [63:0] seed);
        logic [ICACHELINE_SIZE-1:0] line;
        logic [39:0] line_pa;
        int valid_cycles;
        line    = make_line(seed);
        line_pa = {pa[39:6], 6'b0};
        if (exp_resp) exp_q.push_back(line);
        bus.ifill_req_i = '{valid: 1'b1, paddr: pa};
        tick();
        check("ack", bus.ifill_resp_o.ack, 1'b1);
        bus.ifill_req_i.valid = 1'b0;
        valid_cycles = 0;
        for (int c = 0; c <= ready_lat; c++) begin
            if (bus.mem_req_valid_o) valid_cycles++;
            check("req_addr", bus.mem_req_addr_o, line_pa);
            bus.mem_req_ready_i = (c == ready_lat);
            tick();
            if (c == 0) check("ack_pulse", bus.ifill_resp_o.ack, 1'b0);
        end
        bus.mem_req_ready_i = 1'b0;
        check("req_valid_cycles", valid_cycles, ready_lat + 1);
        check("req_valid_drop", bus.mem_req_valid_o, 1'b0);
        for (int b = 0; b < IFILL_BEATS; b++) begin
            repeat (gap) tick();
            bus.mem_resp_valid_i = 1'b1;
            bus.mem_resp_data_i  = line[b*IFILL_BEAT_W +: IFILL_BEAT_W];
            bus.flush_i          = (b == flush_beat);
            bus.inv_valid_i      = (b == inv_beat);
            bus.inv_paddr_i      = inv_pa;
            tick();
            bus.mem_resp_valid_i = 1'b0;
            bus.flush_i          = 1'b0;
            bus.inv_valid_i      = 1'b0;
            if (b == inv_beat) begin
                check("inv_valid", bus.ifill_resp_o.inv.valid, 1'b1);
                check("inv_paddr", bus.ifill_resp_o.inv.paddr, inv_pa[ICACHE_INDEX_SIZE-1:0]);
            end
            if (b < IFILL_BEATS - 1) check("no_early_resp", bus.ifill_resp_o.valid, 1'b0);
        end
        check("resp_valid", bus.ifill_resp_o.valid, exp_resp);
        check("busy_resp", bus.busy_o, 1'b1);
        tick();
        check("resp_pulse", bus.ifill_resp_o.valid, 1'b0);
        check("busy_idle", bus.busy_o, 1'b0);
    endtask

    initial begin
        logic [ICACHELINE_SIZE-1:0] l1;
        logic [ICACHELINE_SIZE-1:0] l2;
        int ack0;
        int resp0;

        rst = 1'b1;
        bus.ifill_req_i      = '0;
        bus.flush_i          = 1'b0;
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_resp_valid_i = 1'b0;
        bus.mem_resp_data_i  = '0;
        bus.inv_valid_i      = 1'b0;
        bus.inv_paddr_i      = '0;
        repeat (2) tick();
        check("rst_resp", bus.ifill_resp_o, '0);
        check("rst_mem_valid", bus.mem_req_valid_o, 1'b0);
        check("rst_busy", bus.busy_o, 1'b0);
        rst = 1'b0;
        tick();

        // T1 basic
        run_fill(40'h00_8000_0044, 0, 0, -1, -1, 40'h0, 1'b1, 64'h0);
        // T2 backpressure and gapped beats
        run_fill(40'h00_8000_1208, 5, 2, -1, -1, 40'h0, 1'b1, 64'h1000);
        // T3 flush mid-fill, then a clean fill
        run_fill(40'h00_8000_0200, 0, 0, 4, -1, 40'h0, 1'b0, 64'h2000);
        run_fill(40'h00_8000_0240, 0, 1, -1, -1, 40'h0, 1'b1, 64'h3000);
        // T4 invalidation collision, then an unrelated invalidation
        run_fill(40'h00_8000_0044, 0, 0, -1, 2, 40'h00_8000_0040, 1'b0, 64'h4000);
        run_fill(40'h00_8000_0040, 0, 0, -1, 5, 40'h00_8000_0080, 1'b1, 64'h5000);

        // T5 async reset in the middle of the fill
        l1 = make_line(64'h6000);
        bus.ifill_req_i = '{valid: 1'b1, paddr: 40'h00_8000_0300};
        tick();
        bus.ifill_req_i.valid = 1'b0;
        bus.mem_req_ready_i   = 1'b1;
        tick();
        bus.mem_req_ready_i   = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus.mem_resp_valid_i = 1'b1;
            bus.mem_resp_data_i  = l1[b*IFILL_BEAT_W +: IFILL_BEAT_W];
            tick();
        end
        bus.mem_resp_data_i = l1[4*IFILL_BEAT_W +: IFILL_BEAT_W];
        #3;
        rst = 1'b1;
        #1;
        check("arst_resp", bus.ifill_resp_o, '0);
        check("arst_mem_valid", bus.mem_req_valid_o, 1'b0);
        check("arst_mem_addr", bus.mem_req_addr_o, 40'h0);
        check("arst_busy", bus.busy_o, 1'b0);
        bus.mem_resp_valid_i = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        tick();
        run_fill(40'h00_8000_0300, 1, 0, -1, -1, 40'h0, 1'b1, 64'h7000);

        // T6 request held high through ack and RESP
        ack0  = n_ack;
        resp0 = n_resp;
        l1 = make_line(64'h8000);
        l2 = make_line(64'h9000);
        exp_q.push_back(l1);
        exp_q.push_back(l2);
        bus.mem_req_ready_i = 1'b1;
        bus.ifill_req_i = '{valid: 1'b1, paddr: 40'h00_8000_0100};
        tick();
        tick();
        for (int b = 0; b < IFILL_BEATS; b++) begin
            bus.mem_resp_valid_i = 1'b1;
            bus.mem_resp_data_i  = l1[b*IFILL_BEAT_W +: IFILL_BEAT_W];
            tick();
        end
        bus.mem_resp_valid_i = 1'b0;
        check("b2b_resp1", bus.ifill_resp_o.valid, 1'b1);
        check("b2b_no_ack_in_resp", bus.ifill_resp_o.ack, 1'b0);
        tick();
        check("b2b_idle", bus.busy_o, 1'b0);
        tick();
        check("b2b_ack2", bus.ifill_resp_o.ack, 1'b1);
        bus.ifill_req_i.valid = 1'b0;
        tick();
        for (int b = 0; b < IFILL_BEATS; b++) begin
            bus.mem_resp_valid_i = 1'b1;
            bus.mem_resp_data_i  = l2[b*IFILL_BEAT_W +: IFILL_BEAT_W];
            tick();
        end
        bus.mem_resp_valid_i = 1'b0;
        check("b2b_resp2", bus.ifill_resp_o.valid, 1'b1);
        tick();
        bus.mem_req_ready_i = 1'b0;
        tick();
        check("b2b_ack_count", n_ack - ack0, 2);
        check("b2b_resp_count", n_resp - resp0, 2);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
